// File: rtl/cpu_datapath.sv
// ============================================================================
// cpu_datapath
// ----------------------------------------------------------------------------
// Multicycle CPU datapath. Holds PC, IR, the 32x32 register file, the ALU,
// ALUOut, MDR and the zero flag. It is driven entirely by per-state strobes
// from the multicycle control FSM and drives a unified, word-addressed
// instruction/data memory whose read data is combinational from mem_addr.
//
// Optional build macro:
//   CPU_DATAPATH_R0_ZERO_EN  - when defined, R0 reads as zero and writes
//                              targeting rd = 0 are dropped. When undefined,
//                              R0 is an ordinary register.
//
// Parameters:
//   ADDR_W    - PC / memory word-address width (1..32)
//   PC_RESET  - PC value loaded on reset
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   writepc    in   PC load enable (PC <= ALU result, truncated)
//   writeir    in   IR load enable (IR <= mem_rdata)
//   selalua    in   ALU A: 1 = PC (zero-extended), 0 = regA
//   selalub    in   ALU B: 00 regB, 01 sext(imm), 10 const 1, 11 sext(imm)
//   aluop      in   00 AND, 01 OR, 10 ADD, 11 SUB
//   selload    in   memory address from ALUOut (load access)
//   selst      in   memory address from ALUOut, read port B uses rd (store)
//   selldst    in   register write data: 1 = MDR, 0 = ALUOut
//   writereg   in   register-file write enable (R[rd])
//   writemem   in   memory write strobe
//   writezero  in   zero-flag load enable (zero <= ALUOut == 0)
//   opcode     out  IR[31:26]
//   zero       out  zero flag
//   mem_addr   out  memory word address
//   mem_wdata  out  memory write data (regB)
//   mem_we     out  memory write enable
//   mem_rdata  in   memory read data
// ============================================================================
module cpu_datapath #(
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              writepc,
    input  logic              writeir,
    input  logic              selalua,
    input  logic [1:0]        selalub,
    input  logic [1:0]        aluop,
    input  logic              selload,
    input  logic              selst,
    input  logic              selldst,
    input  logic              writereg,
    input  logic              writemem,
    input  logic              writezero,
    output logic [5:0]        opcode,
    output logic              zero,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    // ------------------------------------------------------------------
    // Local encodings
    // ------------------------------------------------------------------
    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_ONE  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    // Decoded instruction fields. imm overlaps rt by design (I-format).
    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } ir_fields_t;

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir;
    logic [31:0]       alu_out;
    logic [31:0]       mdr;
    logic              zero_q;
    logic [31:0]       rf [32];

    // ------------------------------------------------------------------
    // Combinational datapath signals
    // ------------------------------------------------------------------
    ir_fields_t        f;
    logic [31:0]       sext_imm;
    logic [4:0]        rb_addr;
    logic [31:0]       reg_a;
    logic [31:0]       reg_b;
    logic [31:0]       pc_ext;
    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    logic [31:0]       alu_res;
    logic [31:0]       rf_wdata;
    logic              rf_we;

    // ------------------------------------------------------------------
    // Instruction field decode
    // ------------------------------------------------------------------
    always_comb begin
        f.op     = ir[31:26];
        f.rd     = ir[25:21];
        f.rs     = ir[20:16];
        f.rt     = ir[15:11];
        f.imm    = ir[15:0];
        sext_imm = {{16{ir[15]}}, ir[15:0]};
    end

    // Stores read the data register through port B using the rd field,
    // so a store can name its source register in the same slot a
    // register-register op uses for its destination.
    assign rb_addr = selst ? f.rd : f.rt;

    // ------------------------------------------------------------------
    // Register file read ports (combinational, no write bypass: a read
    // of the register being written this cycle returns the old value)
    // ------------------------------------------------------------------
`ifdef CPU_DATAPATH_R0_ZERO_EN
    assign reg_a = (f.rs == 5'd0) ? 32'd0 : rf[f.rs];
    assign reg_b = (rb_addr == 5'd0) ? 32'd0 : rf[rb_addr];
`else
    assign reg_a = rf[f.rs];
    assign reg_b = rf[rb_addr];
`endif

    // ------------------------------------------------------------------
    // ALU operand selection
    // ------------------------------------------------------------------
    // PC is zero-extended to 32 bits; built bitwise so ADDR_W = 32 works.
    always_comb begin
        pc_ext              = '0;
        pc_ext[ADDR_W-1:0]  = pc;
    end

    assign alu_a = selalua ? pc_ext : reg_a;

    always_comb begin
        alu_b = reg_b;
        unique case (selalub)
            SRCB_REGB: alu_b = reg_b;
            SRCB_IMM:  alu_b = sext_imm;
            SRCB_ONE:  alu_b = 32'd1;
            SRCB_IMM2: alu_b = sext_imm;
            default:   alu_b = reg_b;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU: 32-bit, wrap-around, no flags out of the combinational path
    // ------------------------------------------------------------------
    always_comb begin
        alu_res = '0;
        unique case (aluop)
            ALU_AND: alu_res = alu_a & alu_b;
            ALU_OR:  alu_res = alu_a | alu_b;
            ALU_ADD: alu_res = alu_a + alu_b;
            ALU_SUB: alu_res = alu_a - alu_b;
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file write
    // ------------------------------------------------------------------
    assign rf_wdata = selldst ? mdr : alu_out;

`ifdef CPU_DATAPATH_R0_ZERO_EN
    assign rf_we = writereg && (f.rd != 5'd0);
`else
    assign rf_we = writereg;
`endif

    // Register contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (rf_we) begin
            rf[f.rd] <= rf_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Sequential architectural state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= PC_RESET;
            ir      <= '0;
            alu_out <= '0;
            mdr     <= '0;
            zero_q  <= 1'b0;
        end else begin
            // ALUOut follows the ALU every cycle; later states pick it up.
            alu_out <= alu_res;

            if (writepc) begin
                pc <= alu_res[ADDR_W-1:0];
            end

            if (writeir) begin
                ir <= mem_rdata;
            end

            if (selload) begin
                mdr <= mem_rdata;
            end

            // Flag comes from the registered ALUOut, i.e. the same value a
            // concurrent ALUOut write-back lands in the register file.
            if (writezero) begin
                zero_q <= (alu_out == 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign opcode    = f.op;
    assign zero      = zero_q;
    assign mem_addr  = (selload || selst) ? alu_out[ADDR_W-1:0] : pc;
    assign mem_wdata = reg_b;
    assign mem_we    = writemem;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed testbench for cpu_datapath. A small word memory lives in the
// bench; instructions are placed at the model PC before each fetch.
module tb_cpu_datapath;

    logic        clk;
    logic        rst;
    logic        writepc, writeir, selalua, selload, selst, selldst;
    logic        writereg, writemem, writezero;
    logic [1:0]  selalub, aluop;
    logic [5:0]  opcode;
    logic        zero;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:65535];
    logic [15:0] pc_model;
    int          checks;
    int          errors;

    cpu_datapath #(.ADDR_W(16), .PC_RESET(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .writepc(writepc), .writeir(writeir), .selalua(selalua),
        .selalub(selalub), .aluop(aluop), .selload(selload), .selst(selst),
        .selldst(selldst), .writereg(writereg), .writemem(writemem),
        .writezero(writezero), .opcode(opcode), .zero(zero),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mki(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [15:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [31:0] mkr(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 11'd0};
    endfunction

    task automatic idle();
        writepc = 0; writeir = 0; selalua = 0; selalub = 2'b00; aluop = 2'b00;
        selload = 0; selst = 0; selldst = 0; writereg = 0; writemem = 0; writezero = 0;
    endtask

    // One clock; memory writes are applied at the edge from pre-edge values.
    task automatic tick();
        logic        we;
        logic [15:0] wa;
        logic [31:0] wd;
        we = mem_we; wa = mem_addr; wd = mem_wdata;
        @(posedge clk);
        if (we) mem[wa] = wd;
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        tick(); tick();
        rst = 1;
        pc_model = 16'h0000;
    endtask

    task automatic fetch(input logic [31:0] instr);
        mem[pc_model] = instr;
        idle();
        writepc = 1; writeir = 1; selalua = 1; selalub = 2'b10; aluop = 2'b10;
        tick();
        idle();
        pc_model = pc_model + 16'd1;
    endtask

    // R[rd] <= mem[addr] via a PC-relative address computation.
    task automatic ld(input logic [4:0] rd, input logic [15:0] addr, input logic [31:0] val);
        logic [15:0] imm;
        mem[addr] = val;
        imm = addr - (pc_model + 16'd1);
        fetch(mki(6'h23, rd, 5'd0, imm));
        selalua = 1; selalub = 2'b01; aluop = 2'b10; tick(); idle();
        selload = 1; tick(); idle();
        writereg = 1; selldst = 1; tick(); idle();
    endtask

    // Register-register op: execute then ALUOut write-back (optionally flag).
    task automatic rop(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic wz);
        fetch(mkr(6'h00, rd, rs, rt));
        selalua = 0; selalub = 2'b00; aluop = op; tick(); idle();
        // ALU driven to a nonzero sum here so the flag must use ALUOut.
        writereg = 1; selldst = 0; writezero = wz; selalub = 2'b10; aluop = 2'b10;
        tick(); idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 0;
        #3;
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp %h", mem_addr, 16'h0000); end
        checks++; if (opcode !== 6'd0) begin errors++; $display("FAIL reset_opcode got %h exp %h", opcode, 6'd0); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b exp %b", zero, 1'b0); end
        tick(); tick();
        rst = 1;
        pc_model = 0;
        tick();
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_release_pc got %h exp %h", mem_addr, 16'h0000); end
        for (int i = 0; i < 5; i++) fetch(32'hFC00_0000);
        checks++; if (mem_addr !== 16'h0005) begin errors++; $display("FAIL pc_after5 got %h exp %h", mem_addr, 16'h0005); end
        checks++; if (opcode !== 6'h3F) begin errors++; $display("FAIL opcode_3f got %h exp %h", opcode, 6'h3F); end
        #2 rst = 0;
        #1;
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL async_reset_pc got %h exp %h", mem_addr, 16'h0000); end
        checks++; if (opcode !== 6'd0) begin errors++; $display("FAIL async_reset_opcode got %h exp %h", opcode, 6'd0); end
        @(posedge clk); #1;
        rst = 1;
        pc_model = 0;
    endtask

    task automatic test_fetch();
        do_reset();
        fetch(32'h1022_0000);
        checks++; if (opcode !== 6'b000100) begin errors++; $display("FAIL fetch_opcode got %h exp %h", opcode, 6'b000100); end
        checks++; if (mem_addr !== 16'h0001) begin errors++; $display("FAIL fetch_pc got %h exp %h", mem_addr, 16'h0001); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fetch_we got %b exp %b", mem_we, 1'b0); end
    endtask

    task automatic test_add_sub();
        do_reset();
        ld(5'd2, 16'h0200, 32'd7);
        ld(5'd3, 16'h0200, 32'd7);
        rop(2'b10, 5'd1, 5'd2, 5'd3, 1'b1);
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add_zero got %b exp %b", zero, 1'b0); end
        selst = 1; #1;
        checks++; if (mem_wdata !== 32'd14) begin errors++; $display("FAIL add_r1 got %h exp %h", mem_wdata, 32'd14); end
        idle();
        rop(2'b11, 5'd1, 5'd2, 5'd3, 1'b1);
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL sub_zero got %b exp %b", zero, 1'b1); end
        selst = 1; #1;
        checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL sub_r1 got %h exp %h", mem_wdata, 32'd0); end
        idle();
        fetch(32'h0000_0000);
        fetch(32'h0000_0000);
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL zero_hold got %b exp %b", zero, 1'b1); end
        #2 rst = 0;
        #1;
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL async_reset_zero got %b exp %b", zero, 1'b0); end
        @(posedge clk); #1;
        rst = 1;
        pc_model = 0;
    endtask

    task automatic test_logic();
        do_reset();
        ld(5'd2, 16'h0210, 32'h0000_0007);
        ld(5'd4, 16'h0211, 32'hF000_000C);
        rop(2'b00, 5'd5, 5'd2, 5'd4, 1'b0);
        rop(2'b01, 5'd6, 5'd2, 5'd4, 1'b0);
        fetch(mkr(6'h00, 5'd0, 5'd0, 5'd5));
        checks++; if (mem_wdata !== 32'h0000_0004) begin errors++; $display("FAIL and_r5 got %h exp %h", mem_wdata, 32'h0000_0004); end
        fetch(mkr(6'h00, 5'd0, 5'd0, 5'd6));
        checks++; if (mem_wdata !== 32'hF000_000F) begin errors++; $display("FAIL or_r6 got %h exp %h", mem_wdata, 32'hF000_000F); end
    endtask

    task automatic test_load_store();
        do_reset();
        mem[16'h0014] = 32'h0;
        ld(5'd7, 16'h0220, 32'h0000_0010);
        ld(5'd8, 16'h0221, 32'hDEAD_BEEF);
        fetch(mki(6'h2B, 5'd8, 5'd7, 16'h0004));
        selalua = 0; selalub = 2'b01; aluop = 2'b10; tick(); idle();
        selst = 1; writemem = 1; #1;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL st_we got %b exp %b", mem_we, 1'b1); end
        checks++; if (mem_addr !== 16'h0014) begin errors++; $display("FAIL st_addr got %h exp %h", mem_addr, 16'h0014); end
        checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_wdata got %h exp %h", mem_wdata, 32'hDEAD_BEEF); end
        tick(); idle(); #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL st_we_drop got %b exp %b", mem_we, 1'b0); end
        checks++; if (mem[16'h0014] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_mem got %h exp %h", mem[16'h0014], 32'hDEAD_BEEF); end
        fetch(mki(6'h23, 5'd9, 5'd7, 16'h0004));
        selalua = 0; selalub = 2'b01; aluop = 2'b10; tick(); idle();
        selload = 1; #1;
        checks++; if (mem_addr !== 16'h0014) begin errors++; $display("FAIL ld_addr got %h exp %h", mem_addr, 16'h0014); end
        tick(); idle();
        writereg = 1; selldst = 1; tick(); idle();
        selst = 1; #1;
        checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_r9 got %h exp %h", mem_wdata, 32'hDEAD_BEEF); end
        idle();
    endtask

    task automatic test_branch();
        do_reset();
        for (int i = 0; i < 9; i++) fetch(32'h0000_0000);
        fetch(mki(6'h04, 5'd0, 5'd0, 16'hFFFC));
        checks++; if (mem_addr !== 16'd10) begin errors++; $display("FAIL br_fetch_pc got %h exp %h", mem_addr, 16'd10); end
        selalua = 1; selalub = 2'b01; aluop = 2'b10; writepc = 1; tick(); idle();
        pc_model = 16'd6;
        checks++; if (mem_addr !== 16'd6) begin errors++; $display("FAIL br_target got %h exp %h", mem_addr, 16'd6); end
        fetch(mki(6'h04, 5'd0, 5'd0, 16'hFFF8));
        selalua = 1; selalub = 2'b11; aluop = 2'b10; writepc = 1; tick(); idle();
        pc_model = 16'hFFFF;
        checks++; if (mem_addr !== 16'hFFFF) begin errors++; $display("FAIL br_to_top got %h exp %h", mem_addr, 16'hFFFF); end
        fetch(32'h0800_0000);
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL pc_wrap got %h exp %h", mem_addr, 16'h0000); end
        checks++; if (opcode !== 6'h02) begin errors++; $display("FAIL wrap_opcode got %h exp %h", opcode, 6'h02); end
    endtask

    task automatic test_r0();
        logic [31:0] exp_r0;
`ifdef CPU_DATAPATH_R0_ZERO_EN
        exp_r0 = 32'h0;
`else
        exp_r0 = 32'h55;
`endif
        do_reset();
        ld(5'd0, 16'h0240, 32'h0000_0055);
        fetch(mki(6'h01, 5'd0, 5'd0, 16'h0000));
        selalua = 0; selalub = 2'b01; aluop = 2'b01; tick(); idle();
        selst = 1; #1;
        checks++; if (mem_addr !== exp_r0[15:0]) begin errors++; $display("FAIL r0_rega got %h exp %h", mem_addr, exp_r0[15:0]); end
        checks++; if (mem_wdata !== exp_r0) begin errors++; $display("FAIL r0_regb got %h exp %h", mem_wdata, exp_r0); end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pc_model = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        rst = 0;
        idle();
        test_reset();
        test_fetch();
        test_add_sub();
        test_logic();
        test_load_store();
        test_branch();
        test_r0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
